dmem_arbiter: RTL and testbench

Shares the single-ported data memory between the two memory-stage lanes of the dual-issue pipeline. Accesses that do not collide pass straight through. When both lanes access memory in the same cycle, the block serialises them in program order: lane 0 (older) goes first and lane 1 (younger) goes one cycle later. During that extra cycle the block raises a one-cycle stall to the pipeline and holds lane 0's load data. It sits between the MEM stage of `mipspipeline` and the data memory and drives that memory's `memwrite`/`dataadr`/`writedata` ports.

---
 rtl/dmem_arbiter_pkg.sv | 33 +++
 rtl/dmem_arbiter_if.sv | 38 +++
 rtl/dmem_arbiter_port_mux.sv | 44 ++++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the data-memory arbiter:
//                arbiter state, memory-port select and the access record.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int MIPS_AW        = 32;
    localparam int MIPS_DW        = 32;
    localparam int CONFLICT_CNT_W = 16;

    typedef enum logic [0:0] {
        ARB_PASS   = 1'b0,
        ARB_SECOND = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_LANE0 = 2'd1,
        SEL_LANE1 = 2'd2,
        SEL_HOLD  = 2'd3
    } port_sel_e;

    typedef struct packed {
        logic               we;
        logic [MIPS_AW-1:0] addr;
        logic [MIPS_DW-1:0] wdata;
    } mem_access_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Bundle of the two MEM-stage lanes and the single data-memory
//                port. master = pipeline/memory side, slave = arbiter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          stall;
    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, readdata,
        input  rdata0, rdata1, stall, memwrite, dataadr, writedata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, readdata,
        output rdata0, rdata1, stall, memwrite, dataadr, writedata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_port_mux.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port_mux
//  Description : Combinational select of lane 0, lane 1 or the hold register
//                onto the data-memory port. memwrite is gated off while the
//                active-low reset is asserted.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_mux
    import mips_pkg::*;
#(
    parameter int AW = MIPS_AW,
    parameter int DW = MIPS_DW
) (
    input  port_sel_e     sel,
    input  mem_access_t   lane0,
    input  mem_access_t   lane1,
    input  mem_access_t   hold,
    input  logic          reset,
    output logic          memwrite,
    output logic [AW-1:0] dataadr,
    output logic [DW-1:0] writedata
);

    mem_access_t w_pick;

    // Choose the access that owns the memory port this cycle; idle drives zeros.
    always_comb begin
        w_pick = '0;
        case (sel)
            SEL_LANE0: w_pick = lane0;
            SEL_LANE1: w_pick = lane1;
            SEL_HOLD:  w_pick = hold;
            default:   w_pick = '0;
        endcase
    end

    // No write may reach memory while reset is held low, whatever the lanes do.
    assign memwrite  = w_pick.we & reset;
    assign dataadr   = w_pick.addr;
    assign writedata = w_pick.wdata;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the single-ported data memory between the two MEM
//                lanes. Colliding accesses are serialised (lane 0 first, lane 1
//                one cycle later) with a one-cycle stall. Optional conflict
//                counter enabled by macro DMEM_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int AW = MIPS_AW,
    parameter int DW = MIPS_DW
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef DMEM_ARB_STATS_EN
    output logic [CONFLICT_CNT_W-1:0] conflict_cnt,
`endif
    dmem_arbiter_if.slave             bus
);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    mem_access_t   r_hold;
    logic [DW-1:0] r_rdata0_hold;
    mem_access_t   w_lane0;
    mem_access_t   w_lane1;
    port_sel_e     w_sel;
    logic          w_conflict;

    assign w_lane0    = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
    assign w_lane1    = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};
    assign w_conflict = (r_state == ARB_PASS) && bus.req0 && bus.req1;

    // State register; asynchronous reset drops any pending lane-1 access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ARB_PASS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a collision costs exactly one SECOND cycle, never two.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_PASS:   w_state_nxt = w_conflict ? ARB_SECOND : ARB_PASS;
            ARB_SECOND: w_state_nxt = ARB_PASS;
            default:    w_state_nxt = ARB_PASS;
        endcase
    end

    // Outputs: port owner, stall and per-lane load data routing.
    always_comb begin
        w_sel      = SEL_NONE;
        bus.stall  = 1'b0;
        bus.rdata0 = '0;
        bus.rdata1 = '0;
        case (r_state)
            ARB_PASS: begin
                if (bus.req0) begin
                    w_sel      = SEL_LANE0;
                    bus.rdata0 = bus.readdata;
                    bus.stall  = bus.req1;
                end else if (bus.req1) begin
                    w_sel      = SEL_LANE1;
                    bus.rdata1 = bus.readdata;
                end
            end
            ARB_SECOND: begin
                w_sel      = SEL_HOLD;
                bus.rdata0 = r_rdata0_hold;
                bus.rdata1 = bus.readdata;
            end
            default: begin
                w_sel = SEL_NONE;
            end
        endcase
    end

    // On a collision park lane 1's access and lane 0's load data for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold        <= '0;
            r_rdata0_hold <= '0;
        end else if (w_conflict) begin
            r_hold        <= w_lane1;
            r_rdata0_hold <= bus.readdata;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [CONFLICT_CNT_W-1:0] r_conflict_cnt;

    // Count PASS->SECOND transitions, saturating at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != {CONFLICT_CNT_W{1'b1}})) begin
            r_conflict_cnt <= r_conflict_cnt + CONFLICT_CNT_W'(1);
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

    dmem_port_mux #(
        .AW (AW),
        .DW (DW)
    ) u_port_mux (
        .sel       (w_sel),
        .lane0     (w_lane0),
        .lane1     (w_lane1),
        .hold      (r_hold),
        .reset     (reset),
        .memwrite  (bus.memwrite),
        .dataadr   (bus.dataadr),
        .writedata (bus.writedata)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter with a small
//                word-addressed memory model behind the arbitrated port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    import mips_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef DMEM_ARB_STATS_EN
        .conflict_cnt (conflict_cnt),
`endif
        .bus          (bus)
    );

    // Memory model: 64 words, asynchronous read, write on rising edge.
    logic [31:0] mem [0:63];

    assign bus.readdata = mem[bus.dataadr[7:2]];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
        mem[20] <= 32'd5;
        forever begin
            @(posedge clk);
            if (bus.memwrite) mem[bus.dataadr[7:2]] <= bus.writedata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    endtask

    task automatic lane0(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    endtask

    task automatic lane1(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held low with two colliding stores: nothing may be written.
        idle();
        lane0(1'b1, 32'd4, 32'd77);
        lane1(1'b1, 32'd8, 32'd88);
        tick();
        tick();
        #3;
        check("rst_memwrite", {31'd0, bus.memwrite}, 32'd0);
        check("rst_mem4", mem[1], 32'd0);
        check("rst_mem8", mem[2], 32'd0);
        idle();
        #1;
        check("rst_stall",     {31'd0, bus.stall}, 32'd0);
        check("rst_dataadr",   bus.dataadr,   32'd0);
        check("rst_writedata", bus.writedata, 32'd0);
        check("rst_rdata0",    bus.rdata0,    32'd0);
        check("rst_rdata1",    bus.rdata1,    32'd0);
`ifdef DMEM_ARB_STATS_EN
        check("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
`endif
        tick();
        reset = 1'b1;

        // Lane 0 store alone passes straight through.
        lane0(1'b1, 32'd84, 32'd7);
        #3;
        check("s0_memwrite",  {31'd0, bus.memwrite}, 32'd1);
        check("s0_dataadr",   bus.dataadr,   32'd84);
        check("s0_writedata", bus.writedata, 32'd7);
        check("s0_stall",     {31'd0, bus.stall}, 32'd0);
        tick();
        idle();
        check("s0_mem84", mem[21], 32'd7);

        // Conflict: lane 0 load 80, lane 1 store 84 <- 13.
        lane0(1'b0, 32'd80, 32'd0);
        lane1(1'b1, 32'd84, 32'd13);
        #3;
        check("c1_stall",    {31'd0, bus.stall}, 32'd1);
        check("c1_dataadr",  bus.dataadr, 32'd80);
        check("c1_memwrite", {31'd0, bus.memwrite}, 32'd0);
        check("c1_rdata0",   bus.rdata0, 32'd5);
        tick();
        // Live inputs must be ignored during the serialised cycle.
        lane0(1'b1, 32'd88, 32'd66);
        lane1(1'b1, 32'd88, 32'd99);
        #3;
        check("c2_memwrite",  {31'd0, bus.memwrite}, 32'd1);
        check("c2_dataadr",   bus.dataadr,   32'd84);
        check("c2_writedata", bus.writedata, 32'd13);
        check("c2_rdata0",    bus.rdata0,    32'd5);
        check("c2_stall",     {31'd0, bus.stall}, 32'd0);
        tick();
        idle();
        check("c2_mem84", mem[21], 32'd13);
        check("c2_mem88", mem[22], 32'd0);

        // Conflict: lane 0 store 84 <- 9, lane 1 load 84 sees the new data.
        lane0(1'b1, 32'd84, 32'd9);
        lane1(1'b0, 32'd84, 32'd0);
        #3;
        check("o1_stall",    {31'd0, bus.stall}, 32'd1);
        check("o1_memwrite", {31'd0, bus.memwrite}, 32'd1);
        tick();
        idle();
        #3;
        check("o2_rdata1",   bus.rdata1, 32'd9);
        check("o2_memwrite", {31'd0, bus.memwrite}, 32'd0);
        check("o2_dataadr",  bus.dataadr, 32'd84);
        tick();

        // Three back-to-back colliding load pairs: stall 1,0,1,0,1,0.
        lane0(1'b0, 32'd80, 32'd0);
        lane1(1'b0, 32'd84, 32'd0);
        for (int i = 0; i < 6; i++) begin
            #3;
            check($sformatf("b2b_stall%0d", i), {31'd0, bus.stall}, (i % 2 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        idle();
`ifdef DMEM_ARB_STATS_EN
        check("b2b_cnt", {16'd0, conflict_cnt}, 32'd5);
`endif

        // Reset during SECOND with a held store to 88: the store is dropped.
        lane0(1'b0, 32'd80, 32'd0);
        lane1(1'b1, 32'd88, 32'd55);
        #3;
        check("r1_stall", {31'd0, bus.stall}, 32'd1);
        tick();
        reset = 1'b0;
        #1;
        check("r2_memwrite", {31'd0, bus.memwrite}, 32'd0);
        tick();
        idle();
        reset = 1'b1;
        #3;
        check("r3_mem88", mem[22], 32'd0);
`ifdef DMEM_ARB_STATS_EN
        check("r3_cnt", {16'd0, conflict_cnt}, 32'd0);
`endif
        // Back in PASS: a lone lane 1 load drives the port directly.
        lane1(1'b0, 32'd88, 32'd0);
        #1;
        check("r4_dataadr", bus.dataadr, 32'd88);
        check("r4_stall",   {31'd0, bus.stall}, 32'd0);
        check("r4_rdata1",  bus.rdata1, 32'd0);
        check("r4_rdata0",  bus.rdata0, 32'd0);
        lane0(1'b0, 32'd80, 32'd0);
        #1;
        check("r4_conflict_stall", {31'd0, bus.stall}, 32'd1);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
